alu_result_collector: RTL



---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_result_fifo.sv | 45 ++++
 rtl/alu_result_collector.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU result collector.
package alu_pkg;
    localparam int ALU_DATA_W = 8;
    typedef struct packed {
        logic                  irq;
        logic [ALU_DATA_W-1:0] data;
    } alu_result_t;
    typedef enum logic [1:0] {IRQ_IDLE, IRQ_PEND, IRQ_WAIT} irq_state_e;
endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: synchronous FIFO of ALU results; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  alu_result_t            wr_data,
    input  logic                   pop,
    output alu_result_t            rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    alu_result_t   mem [DEPTH];
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            wr_ptr   <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count    <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            rd_data  <= do_pop ? mem[rd_ptr] : rd_data;
            rd_valid <= do_pop;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/alu_result_collector.sv
// alu_result_collector: captures ALU results into a FIFO and owns the ALU IRQ handshake.
// Define ALU_RESULT_COLLECTOR_TIMEOUT_EN to add the clear-timeout watchdog (irq_err).
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int RESULT_LAT  = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_enable,
    input  logic [ALU_DATA_W-1:0]  alu_out,
    input  logic                   alu_irq,
    output logic                   alu_irq_clr,
    input  logic                   rd_en,
    output logic [ALU_DATA_W:0]    rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   irq_pending,
    input  logic                   irq_ack,
    output logic                   irq_err
);
    logic [RESULT_LAT-1:0] pipe;
    logic                  capture;
    alu_result_t           head;
    irq_state_e            state, state_next;
    logic                  clr_next;
    assign capture     = pipe[RESULT_LAT-1];
    assign rd_data     = head;
    assign irq_pending = state == IRQ_PEND;

    alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (capture),
        .wr_data ('{irq: alu_irq, data: alu_out}),
        .pop     (rd_en),
        .rd_data (head),
        .rd_valid(rd_valid),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe        <= '0;
            overflow    <= 1'b0;
            state       <= IRQ_IDLE;
            alu_irq_clr <= 1'b0;
        end else begin
            pipe        <= RESULT_LAT'({pipe, alu_enable});
            overflow    <= (capture && full && !rd_en) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
            state       <= state_next;
            alu_irq_clr <= clr_next;
        end
    end

`ifdef ALU_RESULT_COLLECTOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    logic          err_set;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            irq_err <= 1'b0;
        end else begin
            tcnt    <= (state == IRQ_WAIT) ? tcnt + 1'b1 : '0;
            irq_err <= irq_err | err_set;
        end
    end
`else
    assign irq_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        clr_next   = 1'b0;
`ifdef ALU_RESULT_COLLECTOR_TIMEOUT_EN
        err_set    = 1'b0;
`endif
        case (state)
            IRQ_IDLE: state_next = alu_irq ? IRQ_PEND : IRQ_IDLE;
            IRQ_PEND: begin
                state_next = irq_ack ? IRQ_WAIT : IRQ_PEND;
                clr_next   = irq_ack;
            end
            IRQ_WAIT: begin
`ifdef ALU_RESULT_COLLECTOR_TIMEOUT_EN
                // Give up on a stuck interrupt; IDLE re-raises it as a fresh PEND.
                err_set    = alu_irq && tcnt == TW'(TIMEOUT_CYC - 1);
                state_next = (!alu_irq || err_set) ? IRQ_IDLE : IRQ_WAIT;
`else
                state_next = alu_irq ? IRQ_WAIT : IRQ_IDLE;
`endif
            end
            default: state_next = IRQ_IDLE;
        endcase
    end
endmodule
